// File: rtl/uart_command_controller_pkg.sv
// ==== uart_command_controller_pkg : shared definitions for the UART command bridge ====
// Rev 1.0
`default_nettype none

package uart_command_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEV     = 3'd1,
    ST_ADDR_HI = 3'd2,
    ST_ADDR_LO = 3'd3,
    ST_DATA    = 3'd4,
    ST_BUS_REQ = 3'd5,
    ST_TX_LOAD = 3'd6,
    ST_TX_WAIT = 3'd7
  } state_e;

  // CMD byte: bit 7 selects write, bits [6:0] are reserved and must be zero
  localparam int         CMD_RW_BIT = 7;
  localparam logic [7:0] UART_WRITE = 8'h80;
  localparam logic [7:0] UART_READ  = 8'h00;

  localparam logic [7:0] DEV_ID_AABB1 = 8'h01;
  localparam logic [7:0] DEV_ID_AABB2 = 8'h02;
  localparam logic [7:0] DEV_ID_AABB3 = 8'h03;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_command_controller.sv
// ==== uart_command_controller : UART framed command to device-bus bridge ====
// Rev 1.0
`default_nettype none

module uart_command_controller
  import uart_command_controller_pkg::*;
#(
  parameter int BYTE_TIMEOUT = 4096,
  parameter int ACK_TIMEOUT  = 256
) (
  input  logic        iGlobalClock,
  input  logic        iGlobalReset,
  input  logic        iUartByteAvailable,
  input  logic [7:0]  iUartRx,
  input  logic        iUartTxBusy,
  output logic [7:0]  oUartTx,
  output logic        oUartTxByteAvailable,
  output logic        oBusRequest,
  output logic        oBusWrite,
  output logic [7:0]  oBusDeviceId,
  output logic [15:0] oBusAddress,
  output logic [31:0] oBusWriteData,
  input  logic        iBusAck,
  input  logic [31:0] iBusReadData,
  output logic        oBusy,
  output logic        oProtocolError
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int AT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [AT_W-1:0] AT_LAST = AT_W'(ACK_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic           avail_q;
  logic           wr_q, wr_d;
  logic [7:0]     dev_q, dev_d;
  logic [15:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [31:0]    rd_q, rd_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [BT_W-1:0] byte_tmo_q, byte_tmo_d;
  logic [AT_W-1:0] ack_tmo_q, ack_tmo_d;
  logic [7:0]     tx_q, tx_d;
  logic           tx_stb_q, tx_stb_d;
  logic           err_q, err_d;
  logic           byte_edge;

  assign byte_edge = iUartByteAvailable & ~avail_q;

  always_ff @(posedge iGlobalClock or negedge iGlobalReset) begin
    if (!iGlobalReset) begin
      state_q    <= ST_IDLE;
      avail_q    <= 1'b0;
      wr_q       <= 1'b0;
      dev_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_q       <= '0;
      byte_cnt_q <= '0;
      byte_tmo_q <= '0;
      ack_tmo_q  <= '0;
      tx_q       <= '0;
      tx_stb_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      avail_q    <= iUartByteAvailable;
      wr_q       <= wr_d;
      dev_q      <= dev_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      byte_cnt_q <= byte_cnt_d;
      byte_tmo_q <= byte_tmo_d;
      ack_tmo_q  <= ack_tmo_d;
      tx_q       <= tx_d;
      tx_stb_q   <= tx_stb_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    dev_d      = dev_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    byte_cnt_d = byte_cnt_q;
    byte_tmo_d = '0;
    ack_tmo_d  = '0;
    tx_d       = tx_q;
    tx_stb_d   = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (byte_edge) begin
          if (iUartRx[6:0] != 7'd0) begin
            err_d = 1'b1;
          end else begin
            wr_d    = iUartRx[CMD_RW_BIT];
            state_d = ST_DEV;
          end
        end
      end

      ST_DEV, ST_ADDR_HI, ST_ADDR_LO, ST_DATA: begin
        if (byte_edge) begin
          unique case (state_q)
            ST_DEV: begin
              dev_d   = iUartRx;
              state_d = ST_ADDR_HI;
            end
            ST_ADDR_HI: begin
              addr_d[15:8] = iUartRx;
              state_d      = ST_ADDR_LO;
            end
            ST_ADDR_LO: begin
              addr_d[7:0] = iUartRx;
              byte_cnt_d  = 2'd0;
              state_d     = wr_q ? ST_DATA : ST_BUS_REQ;
            end
            default: begin
              data_d     = {data_q[23:0], iUartRx};
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) state_d = ST_BUS_REQ;
            end
          endcase
        end else if (byte_tmo_q == BT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          byte_tmo_d = byte_tmo_q + 1'b1;
        end
      end

      ST_BUS_REQ: begin
        err_d = byte_edge;
        // An ack arriving on the final timeout cycle still completes the access
        if (iBusAck) begin
          if (wr_q) begin
            state_d = ST_IDLE;
          end else begin
            rd_d       = iBusReadData;
            byte_cnt_d = 2'd0;
            state_d    = ST_TX_LOAD;
          end
        end else if (ack_tmo_q == AT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ack_tmo_d = ack_tmo_q + 1'b1;
        end
      end

      ST_TX_LOAD: begin
        err_d = byte_edge;
        if (!iUartTxBusy) begin
          tx_d     = word_byte(rd_q, byte_cnt_q);
          tx_stb_d = 1'b1;
          state_d  = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        err_d = byte_edge;
        // Skip the strobe cycle so the transmitter has a chance to raise busy
        if (!tx_stb_q && !iUartTxBusy) begin
          if (byte_cnt_q == 2'd3) begin
            state_d = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = ST_TX_LOAD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign oUartTx              = tx_q;
  assign oUartTxByteAvailable = tx_stb_q;
  assign oBusRequest          = (state_q == ST_BUS_REQ);
  assign oBusWrite            = wr_q;
  assign oBusDeviceId         = dev_q;
  assign oBusAddress          = addr_q;
  assign oBusWriteData        = data_q;
  assign oBusy                = (state_q != ST_IDLE);
  assign oProtocolError       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_command_controller.sv
// ==== tb_uart_command_controller : scoreboard bench for the UART command bridge ====
// Rev 1.0
`default_nettype none

module tb_uart_command_controller;
  import uart_command_controller_pkg::*;

  localparam int BT = 64;
  localparam int AT = 32;
  localparam logic [1:0] K_BUS = 2'd0;
  localparam logic [1:0] K_TX  = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iUartByteAvailable = 1'b0;
  logic [7:0]  iUartRx = '0;
  logic        iUartTxBusy = 1'b0;
  logic        iBusAck = 1'b0;
  logic [31:0] iBusReadData = '0;
  logic [7:0]  oUartTx;
  logic        oUartTxByteAvailable;
  logic        oBusRequest;
  logic        oBusWrite;
  logic [7:0]  oBusDeviceId;
  logic [15:0] oBusAddress;
  logic [31:0] oBusWriteData;
  logic        oBusy;
  logic        oProtocolError;

  uart_command_controller #(.BYTE_TIMEOUT(BT), .ACK_TIMEOUT(AT)) dut (
    .iGlobalClock         (clk),
    .iGlobalReset         (rst_n),
    .iUartByteAvailable   (iUartByteAvailable),
    .iUartRx              (iUartRx),
    .iUartTxBusy          (iUartTxBusy),
    .oUartTx              (oUartTx),
    .oUartTxByteAvailable (oUartTxByteAvailable),
    .oBusRequest          (oBusRequest),
    .oBusWrite            (oBusWrite),
    .oBusDeviceId         (oBusDeviceId),
    .oBusAddress          (oBusAddress),
    .oBusWriteData        (oBusWriteData),
    .iBusAck              (iBusAck),
    .iBusReadData         (iBusReadData),
    .oBusy                (oBusy),
    .oProtocolError       (oProtocolError)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [56:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  tx_count = 0;
  int  err_count = 0;
  int  req_count = 0;
  int  req_len = 0;
  int  last_req_len = 0;
  int  busy_cnt = 0;
  logic        ack_en = 1'b1;
  logic [31:0] ack_data = '0;
  logic        prev_req = 1'b0, prev_stb = 1'b0, prev_err = 1'b0;
  time t_edge = 0, t_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic push(input logic [1:0] kind, input logic [56:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [1:0] kind, input logic [56:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_output: got kind %0d value %0h, required no output", kind, val);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard", {5'd0, kind, val}, {5'd0, e.kind, e.val});
    end
  endtask

  // Monitor first, then the bus and transmitter responders, all on the inactive edge
  initial begin
    forever begin
      @(negedge clk);
      if (oBusRequest === 1'b1 && !prev_req) begin
        req_count++;
        got(K_BUS, {oBusWrite, oBusDeviceId, oBusAddress, oBusWrite ? oBusWriteData : 32'h0});
      end
      if (oUartTxByteAvailable === 1'b1) begin
        check("tx_while_busy", {63'd0, iUartTxBusy}, 64'd0);
        check("tx_strobe_width", {63'd0, prev_stb}, 64'd0);
        tx_count++;
        got(K_TX, {49'd0, oUartTx});
      end
      if (oProtocolError === 1'b1) begin
        check("err_pulse_width", {63'd0, prev_err}, 64'd0);
        err_count++;
        t_err = $time;
        got(K_ERR, 57'd0);
      end
      prev_stb = (oUartTxByteAvailable === 1'b1);
      prev_err = (oProtocolError === 1'b1);

      if (oBusRequest === 1'b1) begin
        req_len++;
        iBusAck      = ack_en && (req_len == 3);
        iBusReadData = ack_data;
      end else begin
        if (prev_req) last_req_len = req_len;
        req_len = 0;
        iBusAck = 1'b0;
      end
      prev_req = (oBusRequest === 1'b1);

      if (oUartTxByteAvailable === 1'b1) busy_cnt = 3;
      else if (busy_cnt > 0) busy_cnt--;
      iUartTxBusy = (busy_cnt != 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold = 10);
    @(negedge clk);
    iUartRx = b;
    iUartByteAvailable = 1'b1;
    t_edge = $time;
    repeat (hold) @(negedge clk);
    iUartByteAvailable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes[8], input int n);
    for (int i = 0; i < n; i++) send_byte(bytes[i]);
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    while (oBusy !== 1'b0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, oBusy}, 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {oBusy, oBusRequest, oUartTxByteAvailable, oProtocolError, oUartTx,
                 oBusWrite, oBusDeviceId, oBusAddress, oBusWriteData[31:8]}, 64'd0);
    check({name, "_wdata"}, {56'd0, oBusWriteData[7:0]}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] fr[8];
    int base, errs0, reqs0, lat;

    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write "HOLA" to 0x0007
    ack_en = 1'b1;
    push(K_BUS, {1'b1, DEV_ID_AABB1, 16'h0007, 32'h484F4C41});
    fr = '{8'h80, DEV_ID_AABB1, 8'h00, 8'h07, "H", "O", "L", "A"};
    send_frame(fr, 8);
    wait_idle("write_idle", 200);
    check("write_req_len", last_req_len, 3);

    // Read 0x0007, reply 0x41444F53 serialized MSB first
    base = tx_count;
    ack_data = 32'h41444F53;
    push(K_BUS, {1'b0, DEV_ID_AABB1, 16'h0007, 32'h0});
    push(K_TX, 57'h41);
    push(K_TX, 57'h44);
    push(K_TX, 57'h4F);
    push(K_TX, 57'h53);
    fr = '{8'h00, DEV_ID_AABB1, 8'h00, 8'h07, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(fr, 4);
    wait_idle("read_idle", 300);
    check("read_tx_count", tx_count - base, 4);

    // Reserved CMD bits
    reqs0 = req_count;
    push(K_ERR, 57'd0);
    send_byte(8'h85);
    check("reserved_idle", {63'd0, oBusy}, 64'd0);
    check("reserved_no_req", req_count - reqs0, 0);

    // Byte timeout after ADDR_HI, then a clean write
    push(K_ERR, 57'd0);
    fr = '{8'h80, DEV_ID_AABB1, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    send_frame(fr, 3);
    repeat (BT + 10) @(negedge clk);
    check("byte_timeout_idle", {63'd0, oBusy}, 64'd0);
    lat = int'((t_err - t_edge) / 10);
    check("byte_timeout_latency", {63'd0, (lat >= BT && lat <= BT + 2)}, 64'd1);
    push(K_BUS, {1'b1, DEV_ID_AABB2, 16'h1234, 32'hDEADBEEF});
    fr = '{8'h80, DEV_ID_AABB2, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(fr, 8);
    wait_idle("post_timeout_write_idle", 200);

    // Ack timeout with one overrun byte during the request
    ack_en = 1'b0;
    errs0 = err_count;
    push(K_BUS, {1'b1, DEV_ID_AABB1, 16'hABCD, 32'h01020304});
    push(K_ERR, 57'd0);
    push(K_ERR, 57'd0);
    fr = '{8'h80, DEV_ID_AABB1, 8'hAB, 8'hCD, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(fr, 8);
    check("req_held_during_overrun", {63'd0, oBusRequest}, 64'd1);
    send_byte(8'h55, 3);
    wait_idle("ack_timeout_idle", 200);
    check("ack_timeout_req_len", last_req_len, AT);
    check("ack_timeout_err_count", err_count - errs0, 2);
    ack_en = 1'b1;

    // Reset after the second transmitted byte of a read
    base = tx_count;
    ack_data = 32'h11223344;
    push(K_BUS, {1'b0, DEV_ID_AABB3, 16'h0100, 32'h0});
    push(K_TX, 57'h11);
    push(K_TX, 57'h22);
    send_byte(8'h00);
    send_byte(DEV_ID_AABB3);
    send_byte(8'h01);
    send_byte(8'h00, 1);
    for (int i = 0; i < 300 && tx_count < base + 2; i++) begin
      @(negedge clk);
      #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_reset_tx_count", tx_count - base, 2);
    check("post_reset_idle", {63'd0, oBusy}, 64'd0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
